// File: rtl/bch_stream_pkg.sv
// Shared types and elaboration-time helpers for the streaming BCH encoder.
package bch_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int num_words(input int k, input int bits);
    return k / bits;
  endfunction

  function automatic int cnt_width(input int k, input int bits);
    int n;
    n = k / bits;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bch_lfsr_step.sv
// Combinational BITS-wide parity update: folds bits_in (MSB first) into the
// division remainder by GPOLY.
module bch_lfsr_step #(
  parameter int           E     = 8,
  parameter logic [E:0]   GPOLY = 9'h1D1,
  parameter int           BITS  = 1
) (
  input  logic [E-1:0]    lfsr_in,
  input  logic [BITS-1:0] bits_in,
  output logic [E-1:0]    lfsr_out
);

  logic [E-1:0] rem;
  logic         fb;

  always_comb begin
    rem = lfsr_in;
    fb  = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      fb  = bits_in[i] ^ rem[E-1];
      rem = rem << 1;
      if (fb) rem = rem ^ GPOLY[E-1:0];
    end
    lfsr_out = rem;
  end

endmodule

// File: rtl/bch_encode_stream.sv
// Streaming systematic BCH encoder with valid/ready on both sides.
// Define BCH_ENC_SKID_EN to add a one-entry input holding register.
module bch_encode_stream
  import bch_stream_pkg::*;
#(
  parameter int         K     = 7,
  parameter int         E     = 8,
  parameter logic [E:0] GPOLY = 9'h1D1,
  parameter int         BITS  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [K-1:0]   data_in,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [K+E-1:0] data_out,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy
);

  localparam int N  = K + E;
  localparam int NW = num_words(K, BITS);
  localparam int CW = cnt_width(K, BITS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NW - 1);

  if ((K < 1) || (K % BITS != 0)) begin : g_bad_bits
    $error("bch_encode_stream: K must be >= 1 and a multiple of BITS");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [E-1:0]    lfsr_q, lfsr_d, lfsr_nxt;
  logic [K-1:0]    shift_q, shift_d;
  logic [K-1:0]    msg_q, msg_d;
  logic [N-1:0]    dout_q, dout_d;
  logic            live_q;
  logic            accept, start;
  logic [K-1:0]    start_word;

  bch_lfsr_step #(.E(E), .GPOLY(GPOLY), .BITS(BITS)) u_step (
    .lfsr_in  (lfsr_q),
    .bits_in  (shift_q[K-1 -: BITS]),
    .lfsr_out (lfsr_nxt)
  );

`ifdef BCH_ENC_SKID_EN
  logic [K-1:0] hold_q, hold_d;
  logic         hold_full_q, hold_full_d;
  assign din_ready = live_q && !hold_full_q;
`else
  assign din_ready = live_q && (state_q == IDLE);
`endif

  assign accept     = din_valid && din_ready;
  assign dout_valid = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign data_out   = dout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    shift_d    = shift_q;
    msg_d      = msg_q;
    dout_d     = dout_q;
    start      = 1'b0;
    start_word = data_in;
`ifdef BCH_ENC_SKID_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: if (accept) start = 1'b1;
      ENC: begin
        lfsr_d  = lfsr_nxt;
        shift_d = shift_q << BITS;
        if (cnt_q == '0) begin
          state_d = OUT;
          dout_d  = {msg_q, lfsr_nxt};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUT: begin
        if (dout_ready) begin
          state_d = IDLE;
`ifdef BCH_ENC_SKID_EN
          // Buffered word goes first; otherwise a word arriving now starts directly.
          if (hold_full_q) begin
            start       = 1'b1;
            start_word  = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            start = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BCH_ENC_SKID_EN
    if (accept && !start) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
`endif
    if (start) begin
      state_d = ENC;
      msg_d   = start_word;
      shift_d = start_word;
      lfsr_d  = '0;
      cnt_d   = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= '0;
      shift_q <= '0;
      msg_q   <= '0;
      dout_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      shift_q <= shift_d;
      msg_q   <= msg_d;
      dout_q  <= dout_d;
      live_q  <= 1'b1;
    end
  end

`ifdef BCH_ENC_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

endmodule

// File: doc/bch_encode_stream.md
BCH_ENCODE_STREAM -- requirements
Module: bch_encode_stream

Interface
REQ-001 SHALL have parameter K, default 7: message bits per codeword; K >= 1.
REQ-002 SHALL have parameter E, default 8: parity bits, equal to deg(GPOLY); code length N = K+E.
REQ-003 SHALL have parameter GPOLY, default 9'h1D1: generator polynomial, E+1 bits, bit i = coefficient of x^i, bits E and 0 set.
REQ-004 SHALL have parameter BITS, default 1: message bits consumed per cycle; K mod BITS == 0, else elaboration error.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset (decided).
REQ-007 SHALL have port data_in, input, K: message; data_in[K-1] is the highest-degree coefficient.
REQ-008 SHALL have port din_valid, input, 1: message offered.
REQ-009 SHALL have port din_ready, output, 1: message accepted when din_valid && din_ready.
REQ-010 SHALL have port data_out, output, N: systematic codeword; [N-1:E] = message, [E-1:0] = parity.
REQ-011 SHALL have port dout_valid, output, 1: codeword presented.
REQ-012 SHALL have port dout_ready, input, 1: codeword taken when dout_valid && dout_ready.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ENC and OUT.
REQ-015 IDLE SHALL drive din_ready=1; on accept, latch data_in into a shift register, clear the E-bit LFSR, load cycle counter with K/BITS-1, go to ENC.
REQ-016 ENC SHALL each cycle fold the BITS most-significant unconsumed message bits into the LFSR (parity = m(x)*x^E mod GPOLY, MSB first), shift the message BITS left, and decrement the counter.
REQ-017 ENC SHALL go to OUT on the cycle the counter is 0, registering {message, parity} into data_out.
REQ-018 dout_valid SHALL rise exactly K/BITS cycles after the accepting edge.
REQ-019 OUT SHALL hold dout_valid and data_out stable until dout_ready; on handshake go to IDLE, or to ENC per REQ-025.
REQ-020 dout_ready SHALL be ignored outside OUT; din_valid SHALL be ignored while din_ready=0.
REQ-021 data_out SHALL keep the last codeword after handshake until the next OUT entry.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, counter 0, LFSR 0, data_out 0, dout_valid 0, busy 0; din_ready 1 only after rst_n deasserts.
REQ-023 Reset mid-ENC or mid-OUT SHALL discard the word in flight and any buffered word, with no codeword emitted.

Configuration
REQ-024 Macro BCH_ENC_SKID_EN SHALL compile in a one-entry input holding register.
REQ-025 With it: din_ready = !hold_full in any state; a buffered word starts ENC on the OUT handshake cycle (zero bubble); accept and handshake in the same cycle SHALL hand the new word straight to ENC. Without it: din_ready=1 only in IDLE.

Structure
REQ-026 Package bch_stream_pkg SHALL hold the state enum and the functions computing K/BITS and the counter width.
REQ-027 The BITS-wide parity update SHALL be sub-module bch_lfsr_step (combinational, parameters E, GPOLY, BITS).

Verification
REQ-028 Defaults, data_in=7'h01, dout_ready=1 -> data_out=15'h01D1, dout_valid high 7 cycles after accept.
REQ-029 Defaults, data_in=7'h7F -> data_out=15'h7FFF; data_in=7'h00 -> 15'h0000.
REQ-030 BITS=7, data_in=7'h01 -> data_out=15'h01D1 one cycle after accept.
REQ-031 dout_ready low 5 cycles in OUT -> data_out/dout_valid stable; with macro, second word buffered, din_ready low, codeword 2 valid 7 cycles after handshake 1.
REQ-032 rst_n pulsed low at cycle 3 of ENC -> outputs immediately at reset values, no dout_valid afterwards.
